// File: rtl/dec_ecc_pipe.sv
// dec_ecc_pipe: two-stage pipelined extended-Hamming (SEC-DED) decoder.
//
// Stage 1 registers the received codeword together with its syndrome.
// Stage 2 classifies the syndrome, flips the single erroneous bit when
// correctable, and registers the data word with its status.
// The pipeline stalls as a whole: every register advances only when the
// output register is empty or is being drained by the sink.
//
// Code layout (K = log2(CODE_WIDTH)):
//   bits 0..K-1  Hamming parity, column 2^i
//   bit  K       overall parity, column 0
//   bits K+1..   data, columns 3,5,6,7,9,... (non-powers of two, ascending)
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous, active-low reset
//   in_valid / in_ready  input codeword handshake
//   codeword_with_errors received codeword (CODE_WIDTH bits)
//   out_valid / out_ready result handshake
//   data_out             corrected data word (CODE_WIDTH-K-1 bits)
//   err_status           00 clean, 01 corrected, 10 uncorrectable
//   err_pos              index of the corrected bit, 0 otherwise
//   syndrome             raw syndrome {overall, c}, registered with result
//   corr_cnt/uncorr_cnt  saturating error counters
//   cnt_clr              synchronous counter clear
//
// Optional feature macro: DEC_ERR_CNT_EN builds the error counters. When it
// is not defined the counter outputs are tied to zero and cnt_clr is ignored.

module dec_ecc_pipe #(
    parameter int CODE_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [CODE_WIDTH-1:0]                     codeword_with_errors,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [CODE_WIDTH-$clog2(CODE_WIDTH)-2:0]  data_out,
    output logic [1:0]                                err_status,
    output logic [$clog2(CODE_WIDTH)-1:0]             err_pos,
    output logic [$clog2(CODE_WIDTH):0]               syndrome,
    output logic [CNT_WIDTH-1:0]                      corr_cnt,
    output logic [CNT_WIDTH-1:0]                      uncorr_cnt,
    input  logic                                      cnt_clr
);

    localparam int K  = $clog2(CODE_WIDTH);
    localparam int DW = CODE_WIDTH - K - 1;

    // Column (parity-check matrix entry) of codeword bit b.
    function automatic logic [K-1:0] col_of(input int b);
        logic [K-1:0] r;
        int           idx;
        r   = '0;
        idx = K + 1;
        if (b < K) begin
            r[b] = 1'b1;
        end else if (b > K) begin
            for (int v = 3; v < CODE_WIDTH; v++) begin
                if ((v & (v - 1)) != 0) begin
                    if (idx == b) r = v[K-1:0];
                    idx++;
                end
            end
        end
        return r;
    endfunction

    logic                  adv;
    logic                  vld_p1_q, vld_p2_q;
    logic [CODE_WIDTH-1:0] cw_p1_q;
    logic [K:0]            syn_d, syn_p1_q, syn_p2_q;
    logic [CODE_WIDTH-1:0] corr_cw;
    logic [DW-1:0]         data_d, data_q;
    logic [1:0]            status_d, status_q;
    logic [K-1:0]          pos_d, pos_q;

    assign adv      = !vld_p2_q || out_ready;
    assign in_ready = adv;

    // ---- stage 1: syndrome of the incoming codeword ----
    always_comb begin
        logic [K-1:0] col;
        syn_d = '0;
        for (int b = 0; b < CODE_WIDTH; b++) begin
            col = col_of(b);
            for (int i = 0; i < K; i++) begin
                if (col[i]) syn_d[i] = syn_d[i] ^ codeword_with_errors[b];
            end
        end
        syn_d[K] = ^codeword_with_errors;
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            cw_p1_q  <= codeword_with_errors;
            syn_p1_q <= syn_d;
        end
    end

    // ---- stage 2: classify and correct ----
    always_comb begin
        corr_cw  = cw_p1_q;
        status_d = 2'b00;
        pos_d    = '0;
        if (syn_p1_q[K]) begin
            status_d = 2'b01;
            if (syn_p1_q[K-1:0] == '0) begin
                // Only the overall parity bit is wrong; data is untouched.
                pos_d = K'(K);
            end else begin
                for (int b = 0; b < CODE_WIDTH; b++) begin
                    if (b != K && col_of(b) == syn_p1_q[K-1:0]) begin
                        corr_cw[b] = ~cw_p1_q[b];
                        pos_d      = K'(b);
                    end
                end
            end
        end else if (syn_p1_q[K-1:0] != '0) begin
            status_d = 2'b10;
        end
        data_d = corr_cw[CODE_WIDTH-1:K+1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            data_q   <= '0;
            status_q <= '0;
            pos_q    <= '0;
            syn_p2_q <= '0;
        end else if (adv) begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_q   <= data_d;
                status_q <= status_d;
                pos_q    <= pos_d;
                syn_p2_q <= syn_p1_q;
            end
        end
    end

    assign out_valid  = vld_p2_q;
    assign data_out   = data_q;
    assign err_status = status_q;
    assign err_pos    = pos_q;
    assign syndrome   = syn_p2_q;

`ifdef DEC_ERR_CNT_EN
    logic                 xfer;
    logic [CNT_WIDTH-1:0] corr_d, corr_q, unc_d, unc_q;

    assign xfer = vld_p2_q && out_ready;

    // Clear wins over a same-cycle increment; both counters saturate.
    always_comb begin
        corr_d = corr_q;
        unc_d  = unc_q;
        if (cnt_clr) begin
            corr_d = '0;
            unc_d  = '0;
        end else if (xfer) begin
            if (status_q == 2'b01 && corr_q != '1) corr_d = corr_q + CNT_WIDTH'(1);
            if (status_q == 2'b10 && unc_q  != '1) unc_d  = unc_q  + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            corr_q <= '0;
            unc_q  <= '0;
        end else begin
            corr_q <= corr_d;
            unc_q  <= unc_d;
        end
    end

    assign corr_cnt   = corr_q;
    assign uncorr_cnt = unc_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_dec_ecc_pipe.sv
module tb_dec_ecc_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] pos;
        logic [31:0] syn;
    } exp_t;

`ifdef DEC_ERR_CNT_EN
    localparam int CNT_MAX = 3;
    localparam int CNT_SAT = 3;
`else
    localparam int CNT_MAX = 0;
    localparam int CNT_SAT = 0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, cnt_clr;
    logic [31:0] cw32;
    logic [15:0] cw16;
    logic [7:0]  cw8;

    logic ir32, ir16, ir8, ov32, ov16, ov8;
    logic [25:0] d32;  logic [10:0] d16;  logic [3:0] d8;
    logic [1:0]  st32, st16, st8;
    logic [4:0]  p32;  logic [3:0]  p16;  logic [2:0] p8;
    logic [5:0]  s32;  logic [4:0]  s16;  logic [3:0] s8;
    logic [1:0]  cc32, uc32;
    logic [15:0] cc16, uc16, cc8, uc8;

    dec_ecc_pipe #(.CODE_WIDTH(32), .CNT_WIDTH(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .codeword_with_errors(cw32), .out_valid(ov32), .out_ready(out_ready),
        .data_out(d32), .err_status(st32), .err_pos(p32), .syndrome(s32),
        .corr_cnt(cc32), .uncorr_cnt(uc32), .cnt_clr(cnt_clr));
    dec_ecc_pipe #(.CODE_WIDTH(16), .CNT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .codeword_with_errors(cw16), .out_valid(ov16), .out_ready(out_ready),
        .data_out(d16), .err_status(st16), .err_pos(p16), .syndrome(s16),
        .corr_cnt(cc16), .uncorr_cnt(uc16), .cnt_clr(cnt_clr));
    dec_ecc_pipe #(.CODE_WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .codeword_with_errors(cw8), .out_valid(ov8), .out_ready(out_ready),
        .data_out(d8), .err_status(st8), .err_pos(p8), .syndrome(s8),
        .corr_cnt(cc8), .uncorr_cnt(uc8), .cnt_clr(cnt_clr));

    always #5 clk = ~clk;

    int   total = 0, passed = 0, fails = 0;
    exp_t q32[$], q16[$], q8[$];
    exp_t e32, e16, e8;
    int   m_corr = 0, m_unc = 0;
    bit   stall_prev = 1'b0;
    logic [63:0] snap, snap_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int col(input int n, input int b);
        int k, idx;
        k = $clog2(n);
        if (b < k) return 1 << b;
        if (b == k) return 0;
        idx = k + 1;
        for (int v = 3; v < n; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (idx == b) return v;
                idx++;
            end
        end
        return -1;
    endfunction

    function automatic logic [31:0] encode(input int n, input logic [31:0] d);
        logic [31:0] cw;
        logic        p;
        int          k;
        k  = $clog2(n);
        cw = '0;
        for (int j = 0; j < n - k - 1; j++) cw[k+1+j] = d[j];
        for (int i = 0; i < k; i++) begin
            p = 1'b0;
            for (int b = k + 1; b < n; b++) if (((col(n, b) >> i) & 1) != 0) p ^= cw[b];
            cw[i] = p;
        end
        cw[k] = ^cw;
        return cw;
    endfunction

    // a<0: clean; b<0: single flip at a; else double flip at a and b.
    task automatic make(input int n, input int a, input int b,
                        output logic [31:0] cw, output exp_t e);
        int          k;
        logic [31:0] mask, d;
        k    = $clog2(n);
        mask = (32'd1 << (n - k - 1)) - 32'd1;
        d    = $urandom & mask;
        cw   = encode(n, d);
        e    = '{data: d, st: 2'b00, pos: 0, syn: 0};
        if (a >= 0 && b < 0) begin
            cw[a] = ~cw[a];
            e.st  = 2'b01;
            e.pos = a;
            e.syn = (1 << k) | col(n, a);
        end else if (a >= 0) begin
            cw[a]  = ~cw[a];
            cw[b]  = ~cw[b];
            e.st   = 2'b10;
            e.syn  = col(n, a) ^ col(n, b);
            e.data = (cw >> (k + 1)) & mask;
        end
    endtask

    task automatic prep(input int a32, input int b32, input int a16, input int b16,
                        input int a8, input int b8);
        logic [31:0] c;
        make(32, a32, b32, c, e32); cw32 = c;
        make(16, a16, b16, c, e16); cw16 = c[15:0];
        make(8,  a8,  b8,  c, e8);  cw8  = c[7:0];
    endtask

    task automatic push();
        q32.push_back(e32);
        q16.push_back(e16);
        q8.push_back(e8);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send();
        bit ok = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (ir32) begin
                push();
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (q32.size() + q16.size() + q8.size()) != 0; t++)
            @(negedge clk);
        chk("drain_empty", 64'(q32.size() + q16.size() + q8.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        snap = 64'({d32, st32, p32, s32});
        chk("corr_cnt32", 64'(cc32), 64'(m_corr));
        chk("uncorr_cnt32", 64'(uc32), 64'(m_unc));
        if (stall_prev) chk("hold32", snap, snap_prev);
        stall_prev = rst && ov32 && !out_ready;
        snap_prev  = snap;
        if (!rst) begin
            q32.delete(); q16.delete(); q8.delete();
            m_corr = 0;
            m_unc  = 0;
        end else begin
            if (ov32 && out_ready) begin
                chk("q32_has_word", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("data32", 64'(d32), 64'(e.data));
                    chk("status32", 64'(st32), 64'(e.st));
                    chk("pos32", 64'(p32), 64'(e.pos));
                    chk("syn32", 64'(s32), 64'(e.syn));
                    if (cnt_clr) begin
                        m_corr = 0;
                        m_unc  = 0;
                    end else begin
                        if (e.st == 2'b01 && m_corr < CNT_MAX) m_corr++;
                        if (e.st == 2'b10 && m_unc  < CNT_MAX) m_unc++;
                    end
                end
            end else if (cnt_clr) begin
                m_corr = 0;
                m_unc  = 0;
            end
            if (ov16 && out_ready) begin
                chk("q16_has_word", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("data16", 64'(d16), 64'(e.data));
                    chk("status16", 64'(st16), 64'(e.st));
                    chk("pos16", 64'(p16), 64'(e.pos));
                    chk("syn16", 64'(s16), 64'(e.syn));
                end
            end
            if (ov8 && out_ready) begin
                chk("q8_has_word", 64'(q8.size() != 0), 64'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("data8", 64'(d8), 64'(e.data));
                    chk("status8", 64'(st8), 64'(e.st));
                    chk("pos8", 64'(p8), 64'(e.pos));
                    chk("syn8", 64'(s8), 64'(e.syn));
                end
            end
        end
    end

    initial begin
        int a8, b8, ra, rb;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        cw32 = '0; cw16 = '0; cw8 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_data", 64'(d32), 64'd0);
        chk("rst_status", 64'(st32), 64'd0);
        chk("rst_pos", 64'(p32), 64'd0);
        chk("rst_syn", 64'(s32), 64'd0);
        chk("rst_in_ready", 64'(ir32), 64'd1);
        @(posedge clk); #1;

        // Directed N=32 words
        prep(-1, -1, -1, -1, -1, -1);
        cw32 = 32'h0000_0000; e32 = '{data: 0, st: 2'b00, pos: 0,  syn: 32'h00}; send();
        prep(-1, -1, 3, -1, 2, -1);
        cw32 = 32'h0002_0000; e32 = '{data: 0, st: 2'b01, pos: 17, syn: 32'h31}; send();
        prep(-1, -1, 4, 9, 1, 6);
        cw32 = 32'h0000_00C0; e32 = '{data: 3, st: 2'b10, pos: 0,  syn: 32'h06}; send();
        prep(-1, -1, -1, -1, 7, -1);
        cw32 = 32'h0000_0020; e32 = '{data: 0, st: 2'b01, pos: 5,  syn: 32'h20}; send();
        drain();

        // Single-flip sweep for N=16 and N=8
        for (int i = 0; i < 16; i++) begin
            prep($urandom_range(0, 31), -1, i, -1, i % 8, -1);
            send();
        end
        // Double-flip sweep: all N=16 pairs, N=8 pairs cycled
        a8 = 0; b8 = 1;
        for (int a = 0; a < 16; a++) begin
            for (int b = a + 1; b < 16; b++) begin
                ra = $urandom_range(0, 30);
                rb = $urandom_range(ra + 1, 31);
                prep(ra, rb, a, b, a8, b8);
                send();
                b8++;
                if (b8 == 8) begin a8++; b8 = a8 + 1; end
                if (a8 == 7) begin a8 = 0; b8 = 1; end
            end
        end
        drain();

        // Backpressure: out_ready low while four words are offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        prep(10, -1, 2, -1, 3, -1);
        @(negedge clk); chk("bp_ready_w1", 64'(ir32), 64'd1); push();
        @(posedge clk); #1;
        prep(7, 20, 1, 5, 0, 4);
        @(negedge clk); chk("bp_ready_w2", 64'(ir32), 64'd1); push();
        @(posedge clk); #1;
        prep(-1, -1, -1, -1, -1, -1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); chk("bp_stalled", 64'(ir32), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk); chk("bp_ready_w3", 64'(ir32), 64'd1); push();
        @(posedge clk); #1;
        prep(31, -1, 15, -1, 7, -1);
        @(negedge clk); chk("bp_ready_w4", 64'(ir32), 64'd1); push();
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset mid-stream
        prep(17, -1, 1, -1, 1, -1); send();
        prep(3, 9, 2, 3, 2, 3);     send();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(ov32), 64'd0);
        chk("midrst_corr", 64'(cc32), 64'd0);
        chk("midrst_uncorr", 64'(uc32), 64'd0);
        chk("midrst_in_ready", 64'(ir32), 64'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_flushed", 64'(ov32), 64'd0);

        // Counter saturation with five correctable words
        for (int i = 0; i < 5; i++) begin
            prep($urandom_range(0, 31), -1, -1, -1, -1, -1);
            send();
        end
        drain();
        chk("corr_saturated", 64'(cc32), 64'(CNT_SAT));

        // Clear coinciding with a correctable transfer
        out_ready = 1'b0;
        prep(12, -1, -1, -1, -1, -1);
        send();
        @(posedge clk); #1;
        chk("clr_pre_valid", 64'(ov32), 64'd1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_corr_zero", 64'(cc32), 64'd0);
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
